// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Define ILLEGAL_TRAP_EN to route undefined opcodes through a TRAP state.
module multicycle_control_unit #(
    parameter int         MD_TIMEOUT     = 64,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       md_done,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic       md_start,
    output logic       md_op,
    output logic       md_timeout,
    output logic       illegal_instr,
    output logic [3:0] state
);
    localparam int CW = $clog2(MD_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
`ifdef ILLEGAL_TRAP_EN
        S_TRAP   = 4'd14,
`endif
        S_JAL    = 4'd12, S_MDWAIT = 4'd13
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          timeout_r;

    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t ns;
        case (op)
            6'b000000: begin
                if (fn == 6'b011000 || fn == 6'b011010) ns = S_MDWAIT;
                else ns = S_RTEX;
            end
            6'b100011, 6'b101011:                   ns = S_MEMADR;
            6'b000100, 6'b000101:                   ns = S_BRANCH;
            6'b001000, 6'b001010, 6'b001101, 6'b001111: ns = S_IMMEX;
            6'b000010:                              ns = S_JUMP;
            6'b000011:                              ns = S_JAL;
`ifdef ILLEGAL_TRAP_EN
            default:                                ns = S_TRAP;
`else
            default:                                ns = S_FETCH;
`endif
        endcase
        return ns;
    endfunction

    // State sequencing, mult/div wait counter and sticky abort flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_FETCH;
            cnt_r     <= {CW{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r <= {CW{1'b0}};
            case (state_r)
                S_FETCH:  state_r <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: state_r <= decode_next(opcode, funct);
                S_MEMADR: begin
                    if (opcode == 6'b101011) state_r <= S_MEMWR;
                    else state_r <= S_MEMRD;
                end
                S_MEMRD:  state_r <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_r <= S_FETCH;
                S_MEMWR:  state_r <= mem_ready ? S_FETCH : S_MEMWR;
                S_RTEX:   state_r <= S_RTWB;
                S_RTWB:   state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                S_IMMEX:  state_r <= S_IMMWB;
                S_IMMWB:  state_r <= S_FETCH;
                S_JUMP:   state_r <= S_FETCH;
                S_JAL:    state_r <= S_FETCH;
                // md_done wins over the abort on the last allowed cycle.
                S_MDWAIT: begin
                    if (md_done) begin
                        state_r <= S_FETCH;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r   <= S_FETCH;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= S_MDWAIT;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                S_TRAP:   state_r <= S_FETCH;
`endif
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the state register; FETCH qualifies its writes with mem_ready.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        md_start    = 1'b0;
        md_op       = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b0;
`endif
        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RTWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = opcode[0];
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    6'b001010: ALUOp = 2'b01;
                    6'b001101: ALUOp = 2'b11;
                    default:   ALUOp = 2'b00;
                endcase
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                if (opcode == 6'b001111) MemtoReg = 2'b10;
                else MemtoReg = 2'b00;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
            end
            S_MDWAIT: begin
                md_start = (cnt_r == {CW{1'b0}});
                md_op    = funct[1];
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                PCWrite       = 1'b1;
                PCSource      = EXC_VECTOR_SEL;
                illegal_instr = 1'b1;
            end
`endif
            default: begin
                MemRead = 1'b0;
            end
        endcase
    end

`ifndef ILLEGAL_TRAP_EN
    logic unused_exc_s;
    assign unused_exc_s  = ^EXC_VECTOR_SEL;
    assign illegal_instr = 1'b0;
`endif

    assign md_timeout = timeout_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle expected state and
// control vector are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       mem_ready, md_done;
    logic       PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, PCSource, ALUOp, ALUSrcB, RegDst;
    logic       ALUSrcA, RegWrite, md_start, md_op, md_timeout, illegal_instr;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [26:0] exp_q[$];
    logic [26:0] e;
    logic [3:0]  prev_st = 4'd0;
    logic        exp_tout = 1'b0;

    multicycle_control_unit #(.MD_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .md_done(md_done),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNE(BranchNE),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .md_start(md_start), .md_op(md_op),
        .md_timeout(md_timeout), .illegal_instr(illegal_instr), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference control vector for one cycle, transcribed from the state table.
    function automatic logic [22:0] exp_ctl(input logic [3:0] st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic mr,
                                            input logic first, input logic tout);
        logic pw, pwc, bne, iord, mrd, mwr, irw, alua, rw, mds, mdo, ill;
        logic [1:0] m2r, pcs, aop, alub, rd;
        {pw, pwc, bne, iord, mrd, mwr, irw, alua, rw, mds, mdo, ill} = 12'b0;
        {m2r, pcs, aop, alub, rd} = 10'b0;
        case (st)
            4'd0:  begin mrd = 1'b1; alub = 2'b01; irw = mr; pw = mr; end
            4'd1:  alub = 2'b11;
            4'd2:  begin alua = 1'b1; alub = 2'b10; end
            4'd3:  begin mrd = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 2'b01; end
            4'd5:  begin mwr = 1'b1; iord = 1'b1; end
            4'd6:  begin alua = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 2'b01; end
            4'd8:  begin alua = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; bne = op[0]; end
            4'd9:  begin
                alua = 1'b1; alub = 2'b10;
                if (op == 6'b001010) aop = 2'b01;
                else if (op == 6'b001101) aop = 2'b11;
                else aop = 2'b00;
            end
            4'd10: begin rw = 1'b1; m2r = (op == 6'b001111) ? 2'b10 : 2'b00; end
            4'd11: begin pw = 1'b1; pcs = 2'b10; end
            4'd12: begin pw = 1'b1; pcs = 2'b10; rw = 1'b1; rd = 2'b10; m2r = 2'b11; end
            4'd13: begin mds = first; mdo = fn[1]; end
            4'd14: begin pw = 1'b1; pcs = 2'b11; ill = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, bne, iord, mrd, mwr, irw, m2r, pcs, aop, alua, alub,
                rw, rd, mds, mdo, tout, ill};
    endfunction

    function automatic logic [22:0] obs_ctl();
        return {PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst,
                md_start, md_op, md_timeout, illegal_instr};
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, advance.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic md);
        mem_ready = mr;
        md_done   = md;
        exp_q.push_back({st, exp_ctl(st, opcode, funct, mr, prev_st != 4'd13, exp_tout)});
        prev_st = st;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("state", {28'b0, state}, {28'b0, e[26:23]});
            check_val($sformatf("ctl@st%0d", e[26:23]), {9'b0, obs_ctl()}, {9'b0, e[22:0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; md_done = 1'b0;
        instr(6'b000000, 6'b100000);
        #3;
        check_val("reset_state", {28'b0, state}, 32'd0);
        check_val("reset_ctl", {9'b0, obs_ctl()}, {9'b0, exp_ctl(4'd0, opcode, funct, 1'b0, 1'b1, 1'b0)});
        #9 reset = 1'b0;
        @(posedge clk); #1;

        // add, with a stray md_done in FETCH
        cyc(4'd0, 1'b1, 1'b1); cyc(4'd1, 1'b1, 1'b0); cyc(4'd6, 1'b1, 1'b0); cyc(4'd7, 1'b1, 1'b0);
        // lw with 3 wait cycles
        instr(6'b100011, 6'b000000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'd3, 1'b0, 1'b0);
        cyc(4'd3, 1'b1, 1'b0); cyc(4'd4, 1'b0, 1'b0);
        // sw with a fetch stall
        instr(6'b101011, 6'b000000);
        cyc(4'd0, 1'b0, 1'b0); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b0, 1'b0); cyc(4'd2, 1'b0, 1'b0);
        cyc(4'd5, 1'b0, 1'b0); cyc(4'd5, 1'b1, 1'b0);
        // beq / bne
        instr(6'b000100, 6'b000000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd8, 1'b1, 1'b0);
        instr(6'b000101, 6'b000000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd8, 1'b1, 1'b0);
        // addi, subi, ori, lui
        instr(6'b001000, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd9, 1'b1, 1'b0); cyc(4'd10, 1'b1, 1'b0);
        instr(6'b001010, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd9, 1'b1, 1'b0); cyc(4'd10, 1'b1, 1'b0);
        instr(6'b001101, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd9, 1'b1, 1'b0); cyc(4'd10, 1'b1, 1'b0);
        instr(6'b001111, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd9, 1'b1, 1'b0); cyc(4'd10, 1'b1, 1'b0);
        // j, jal
        instr(6'b000010, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd11, 1'b1, 1'b0);
        instr(6'b000011, 6'b000000); cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd12, 1'b1, 1'b0);
        // mult finishing on its third wait cycle
        instr(6'b000000, 6'b011000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0);
        cyc(4'd13, 1'b0, 1'b0); cyc(4'd13, 1'b0, 1'b0); cyc(4'd13, 1'b0, 1'b1);
        // div finishing on the last allowed cycle: no abort
        instr(6'b000000, 6'b011010);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(4'd13, 1'b0, 1'b0);
        cyc(4'd13, 1'b0, 1'b1);
        // div never finishing: abort after 8 cycles
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(4'd13, 1'b0, 1'b0);
        exp_tout = 1'b1;
        // mult after abort keeps the sticky flag
        instr(6'b000000, 6'b011000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0);
        cyc(4'd13, 1'b0, 1'b0); cyc(4'd13, 1'b0, 1'b0); cyc(4'd13, 1'b0, 1'b1);
        // undefined opcode
        instr(6'b111111, 6'b000000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        cyc(4'd14, 1'b1, 1'b0);
`endif
        // reset asserted mid-MEMRD
        instr(6'b100011, 6'b000000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd2, 1'b1, 1'b0); cyc(4'd3, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        exp_tout = 1'b0;
        check_val("midwait_reset_state", {28'b0, state}, 32'd0);
        check_val("midwait_reset_ctl", {9'b0, obs_ctl()}, {9'b0, exp_ctl(4'd0, opcode, funct, mem_ready, 1'b1, 1'b0)});
        #2 reset = 1'b0;
        prev_st = 4'd0;
        @(posedge clk); #1;
        instr(6'b000000, 6'b100000);
        cyc(4'd0, 1'b1, 1'b0); cyc(4'd1, 1'b1, 1'b0); cyc(4'd6, 1'b1, 1'b0); cyc(4'd7, 1'b1, 1'b0);
        cyc(4'd0, 1'b0, 1'b0);

        if (exp_q.size() != 0) check_val("queue_drain", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle MIPS control FSM. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback across several clocks. It sits between the instruction register (opcode/funct held stable after IRWrite), the datapath muxes, a shared instruction/data memory with a ready handshake, and an external iterative multiply/divide unit. Supports R-type, mult/div, lw, sw, beq, bne, addi, subi, ori, lui, j and jal.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MDWAIT before aborting; counter width is $clog2(MD_TIMEOUT)+1.
EXC_VECTOR_SEL, 2'b11, PCSource code that selects the exception vector; used only when ILLEGAL_TRAP_EN is defined.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
opcode  in  6  IR[31:26].
funct  in  6  IR[5:0].
mem_ready  in  1  memory access complete this cycle.
md_done  in  1  mult/div unit finished.
PCWrite  out  1  unconditional PC load.
PCWriteCond  out  1  PC load if the branch condition holds.
BranchNE  out  1  0 = take branch on Zero (beq), 1 = take on !Zero (bne).
IorD  out  1  0 = memory address from PC, 1 = from ALUOut.
MemRead  out  1  memory read strobe.
MemWrite  out  1  memory write strobe.
IRWrite  out  1  instruction register load.
MemtoReg  out  2  writeback source: 00 ALUOut, 01 MDR, 10 lui immediate, 11 PC (link).
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
ALUOp  out  2  00 add, 01 sub, 10 decode funct, 11 or.
ALUSrcA  out  1  0 = PC, 1 = register A.
ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
RegWrite  out  1  register file write enable.
RegDst  out  2  destination register: 00 rt, 01 rd, 10 $31.
md_start  out  1  one-cycle start pulse to the mult/div unit.
md_op  out  1  0 = mult, 1 = div (equals funct[1]).
md_timeout  out  1  sticky flag: a mult/div operation was aborted.
illegal_instr  out  1  one-cycle pulse on an undefined opcode (macro only).
state  out  4  current state, for debug.

Behaviour:
- Reset is asynchronous and active-high. On reset: state = FETCH, cycle counter = 0, md_timeout = 0.
- Outputs are a Moore decode of the state register. Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, JAL=12, MDWAIT=13, TRAP=14.
- FETCH:
  - Always asserts MemRead=1, ALUSrcB=01.
  - While mem_ready=0: IRWrite=0 and PCWrite=0; the FSM stays in FETCH.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in the same cycle; next state DECODE.
- DECODE: ALUSrcB=11 (precompute the branch target). Next state by opcode:
  - 000000: MDWAIT if funct is 011000 or 011010, else RTEX.
  - 100011 or 101011: MEMADR.
  - 000100 or 000101: BRANCH.
  - 001000, 001010, 001101, 001111: IMMEX.
  - 000010: JUMP.
  - 000011: JAL.
  - Any other opcode: FETCH (executed as a nop).
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=01, RegDst=00. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then FETCH.
- RTEX: ALUSrcA=1, ALUOp=10. Next state RTWB.
- RTWB: RegWrite=1, RegDst=01. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=opcode[0]. Next state FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp is 00 for addi, 01 for subi, 11 for ori, 00 for lui. Next state IMMWB.
- IMMWB: RegWrite=1, RegDst=00. MemtoReg=10 for lui, else 00. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11. Next state FETCH.
- MDWAIT:
  - md_start=1 only while the counter = 0; md_op=funct[1] throughout.
  - The counter increments every cycle spent in MDWAIT.
  - md_done=1 → FETCH.
  - Counter = MD_TIMEOUT-1 with md_done=0 → set md_timeout, then FETCH.
  - md_done has priority if it arrives on the timeout cycle (no abort).
  - The counter clears on every exit from MDWAIT.
  - No register write here; HI/LO live in the mult/div unit.
- mem_ready or md_done asserted outside the states that wait on them is ignored.
- md_timeout clears only on reset.
- Reset asserted in any state, including mid-wait, returns to FETCH on assertion with no glitch writes. The FSM restarts on the first clk edge after deassertion.

Optional Feature:
ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE goes to TRAP. TRAP asserts PCWrite=1, PCSource=EXC_VECTOR_SEL and illegal_instr=1 for one cycle, then FETCH.
- Not defined: the TRAP state does not exist, illegal_instr is tied to 0, PCSource never equals 11, and undefined opcodes go DECODE → FETCH.

Test Plan:
- add (opcode 0, funct 100000), mem_ready held 1 → states 0,1,6,7,0; RegWrite=1 with RegDst=01 only in RTWB; 4 cycles per instruction.
- lw with mem_ready low for 3 cycles in MEMRD → state stays 3 for 3 cycles; MemRead=IorD=1; MEMWB writes with MemtoReg=01; 8 cycles total.
- bne (000101) → BRANCH with PCWriteCond=1, BranchNE=1, PCSource=01; beq gives BranchNE=0.
- jal → JAL cycle shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=11.
- div (funct 011010), md_done never asserted, MD_TIMEOUT=8 → exactly one md_start pulse, md_op=1, return to FETCH after 8 MDWAIT cycles, md_timeout=1; repeating with md_done at cycle 3 leaves md_timeout unchanged.
- Opcode 111111: with ILLEGAL_TRAP_EN defined → TRAP with illegal_instr pulse and PCSource=11; without the macro → DECODE → FETCH. Separately, reset asserted mid-MEMRD → state=0 on assertion.
